// File: rtl/sys_axi_master_if.sv
// Bundles the system-bus request/response signals and the AXI3 master
// channels used by sys_axi_master.
//   master : view of sys_axi_master (takes sys requests, drives AXI).
//   slave  : view of whatever sits around it (requester plus AXI slave).
// The *_o / *_i suffixes follow the master's point of view on both modports.
// axi_bid_i, axi_rid_i and axi_rlast_i exist only for the environment. The
// master issues single-beat transfers with one fixed ID, so it never reads them.
interface sys_axi_master_if #(
  parameter int AXI_DW = 32,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8
);
  localparam int AXI_SW = AXI_DW / 8;

  // system bus
  logic [AXI_AW-1:0] sys_addr_i;
  logic [AXI_DW-1:0] sys_wdata_i;
  logic [AXI_SW-1:0] sys_sel_i;
  logic              sys_wen_i;
  logic              sys_ren_i;
  logic [AXI_DW-1:0] sys_rdata_o;
  logic              sys_ack_o;
  logic              sys_err_o;

  // write address channel
  logic [AXI_IW-1:0] axi_awid_o;
  logic [AXI_AW-1:0] axi_awaddr_o;
  logic [3:0]        axi_awlen_o;
  logic [2:0]        axi_awsize_o;
  logic [1:0]        axi_awburst_o;
  logic [1:0]        axi_awlock_o;
  logic [3:0]        axi_awcache_o;
  logic [2:0]        axi_awprot_o;
  logic              axi_awvalid_o;
  logic              axi_awready_i;

  // write data channel
  logic [AXI_IW-1:0] axi_wid_o;
  logic [AXI_DW-1:0] axi_wdata_o;
  logic [AXI_SW-1:0] axi_wstrb_o;
  logic              axi_wlast_o;
  logic              axi_wvalid_o;
  logic              axi_wready_i;

  // write response channel
  logic [AXI_IW-1:0] axi_bid_i;
  logic [1:0]        axi_bresp_i;
  logic              axi_bvalid_i;
  logic              axi_bready_o;

  // read address channel
  logic [AXI_IW-1:0] axi_arid_o;
  logic [AXI_AW-1:0] axi_araddr_o;
  logic [3:0]        axi_arlen_o;
  logic [2:0]        axi_arsize_o;
  logic [1:0]        axi_arburst_o;
  logic [1:0]        axi_arlock_o;
  logic [3:0]        axi_arcache_o;
  logic [2:0]        axi_arprot_o;
  logic              axi_arvalid_o;
  logic              axi_arready_i;

  // read data channel
  logic [AXI_IW-1:0] axi_rid_i;
  logic [AXI_DW-1:0] axi_rdata_i;
  logic [1:0]        axi_rresp_i;
  logic              axi_rlast_i;
  logic              axi_rvalid_i;
  logic              axi_rready_o;

  modport master (
    input  sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
    output sys_rdata_o, sys_ack_o, sys_err_o,
    output axi_awid_o, axi_awaddr_o, axi_awlen_o, axi_awsize_o, axi_awburst_o,
           axi_awlock_o, axi_awcache_o, axi_awprot_o, axi_awvalid_o,
    input  axi_awready_i,
    output axi_wid_o, axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o,
    input  axi_wready_i,
    input  axi_bresp_i, axi_bvalid_i,
    output axi_bready_o,
    output axi_arid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
           axi_arlock_o, axi_arcache_o, axi_arprot_o, axi_arvalid_o,
    input  axi_arready_i,
    input  axi_rdata_i, axi_rresp_i, axi_rvalid_i,
    output axi_rready_o
  );

  modport slave (
    output sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
    input  sys_rdata_o, sys_ack_o, sys_err_o,
    input  axi_awid_o, axi_awaddr_o, axi_awlen_o, axi_awsize_o, axi_awburst_o,
           axi_awlock_o, axi_awcache_o, axi_awprot_o, axi_awvalid_o,
    output axi_awready_i,
    input  axi_wid_o, axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o,
    output axi_wready_i,
    output axi_bid_i, axi_bresp_i, axi_bvalid_i,
    input  axi_bready_o,
    input  axi_arid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o,
           axi_arlock_o, axi_arcache_o, axi_arprot_o, axi_arvalid_o,
    output axi_arready_i,
    output axi_rid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i, axi_rvalid_i,
    input  axi_rready_o
  );
endinterface

// File: rtl/sys_axi_master.sv
// Turns one outstanding system-bus request (write or read) into a single-beat
// AXI3 transaction. It returns a one-cycle ack together with an error flag and,
// for reads, the registered read data.
// Ports:
//   axi_clk_i : clock, rising edge
//   axi_rst_i : asynchronous active-high reset
//   bus       : sys_axi_master_if.master (system request side + AXI channels)
//
// state | meaning
// IDLE  | waiting for sys_wen_i / sys_ren_i
// WREQ  | AW and W offered, each drops on its own handshake
// WRESP | bready high, waiting for the B response
// RREQ  | AR offered until arready
// RRESP | rready high, waiting for the R beat
module sys_axi_master #(
  parameter int          AXI_DW = 32,
  parameter int          AXI_AW = 32,
  parameter int          AXI_IW = 8,
  parameter int unsigned AXI_ID = 0,
  parameter int          TMO_W  = 6
) (
  input  logic             axi_clk_i,
  input  logic             axi_rst_i,
  sys_axi_master_if.master bus
);
  localparam int AXI_SW = AXI_DW / 8;

  typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RRESP} state_t;

  state_t            state_q, state_d;
  logic              aw_q, aw_d;
  logic              w_q, w_d;
  logic              ar_q, ar_d;
  logic              b_q, b_d;
  logic              r_q, r_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [AXI_DW-1:0] rdata_q, rdata_d;
  logic [AXI_AW-1:0] addr_q, addr_d;
  logic [AXI_DW-1:0] wdata_q, wdata_d;
  logic [AXI_SW-1:0] sel_q, sel_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [TMO_W-1:0]  tmo_nxt;
  logic              tmo_hit;

  // The timeout is judged on the value the counter is about to take. The
  // error ack then leaves the register on the same edge the MSB sets, which
  // is 2^(TMO_W-1) edges after accept.
  assign tmo_nxt = tmo_q + 1'b1;
  assign tmo_hit = tmo_nxt[TMO_W-1];

  always_ff @(posedge axi_clk_i or posedge axi_rst_i) begin
    if (axi_rst_i) begin
      state_q <= IDLE;
      aw_q    <= 1'b0;
      w_q     <= 1'b0;
      ar_q    <= 1'b0;
      b_q     <= 1'b0;
      r_q     <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      aw_q    <= aw_d;
      w_q     <= w_d;
      ar_q    <= ar_d;
      b_q     <= b_d;
      r_q     <= r_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    aw_d    = aw_q;
    w_d     = w_q;
    ar_d    = ar_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      IDLE: begin
        // A write wins over a simultaneous read; the read is simply dropped.
        if (bus.sys_wen_i) begin
          addr_d  = bus.sys_addr_i;
          wdata_d = bus.sys_wdata_i;
          sel_d   = bus.sys_sel_i;
          aw_d    = 1'b1;
          w_d     = 1'b1;
          tmo_d   = '0;
          state_d = WREQ;
        end else if (bus.sys_ren_i) begin
          addr_d  = bus.sys_addr_i;
          ar_d    = 1'b1;
          tmo_d   = '0;
          state_d = RREQ;
        end
      end

      WREQ: begin
        tmo_d = tmo_nxt;
        aw_d  = aw_q & ~bus.axi_awready_i;
        w_d   = w_q & ~bus.axi_wready_i;
        if (tmo_hit) begin
          aw_d    = 1'b0;
          w_d     = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (!aw_d && !w_d) begin
          state_d = WRESP;
        end
      end

      WRESP: begin
        tmo_d = tmo_nxt;
        // A response landing on the timeout edge still completes normally.
        if (bus.axi_bvalid_i) begin
          ack_d   = 1'b1;
          err_d   = bus.axi_bresp_i[1];
          state_d = IDLE;
        end else if (tmo_hit) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      RREQ: begin
        tmo_d = tmo_nxt;
        ar_d  = ar_q & ~bus.axi_arready_i;
        if (tmo_hit) begin
          ar_d    = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (!ar_d) begin
          state_d = RRESP;
        end
      end

      RRESP: begin
        tmo_d = tmo_nxt;
        if (bus.axi_rvalid_i) begin
          rdata_d = bus.axi_rdata_i;
          ack_d   = 1'b1;
          err_d   = bus.axi_rresp_i[1];
          state_d = IDLE;
        end else if (tmo_hit) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        aw_d    = 1'b0;
        w_d     = 1'b0;
        ar_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // The ready outputs are registered straight from the next state, so they
  // rise in the first cycle of the response phase and clear on leaving it.
  assign b_d = (state_d == WRESP);
  assign r_d = (state_d == RRESP);

  assign bus.sys_rdata_o   = rdata_q;
  assign bus.sys_ack_o     = ack_q;
  assign bus.sys_err_o     = err_q;

  assign bus.axi_awid_o    = AXI_IW'(AXI_ID);
  assign bus.axi_awaddr_o  = addr_q;
  assign bus.axi_awlen_o   = 4'd0;
  assign bus.axi_awsize_o  = 3'($clog2(AXI_SW));
  assign bus.axi_awburst_o = 2'b01;
  assign bus.axi_awlock_o  = 2'b00;
  assign bus.axi_awcache_o = 4'd0;
  assign bus.axi_awprot_o  = 3'd0;
  assign bus.axi_awvalid_o = aw_q;

  assign bus.axi_wid_o     = AXI_IW'(AXI_ID);
  assign bus.axi_wdata_o   = wdata_q;
  assign bus.axi_wstrb_o   = sel_q;
  assign bus.axi_wlast_o   = 1'b1;
  assign bus.axi_wvalid_o  = w_q;

  assign bus.axi_bready_o  = b_q;

  assign bus.axi_arid_o    = AXI_IW'(AXI_ID);
  assign bus.axi_araddr_o  = addr_q;
  assign bus.axi_arlen_o   = 4'd0;
  assign bus.axi_arsize_o  = 3'($clog2(AXI_SW));
  assign bus.axi_arburst_o = 2'b01;
  assign bus.axi_arlock_o  = 2'b00;
  assign bus.axi_arcache_o = 4'd0;
  assign bus.axi_arprot_o  = 3'd0;
  assign bus.axi_arvalid_o = ar_q;

  assign bus.axi_rready_o  = r_q;
endmodule

// File: tb/tb_sys_axi_master.sv
module tb_sys_axi_master;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int IW  = 8;
  localparam int TMO = 32;
  localparam int WIN = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sys_axi_master_if #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW)) bus ();

  sys_axi_master #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_ID(0), .TMO_W(6)) dut (
    .axi_clk_i(clk),
    .axi_rst_i(rst),
    .bus      (bus)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  logic [31:0] rdata_model = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.sys_wen_i     = 1'b0;
    bus.sys_ren_i     = 1'b0;
    bus.axi_awready_i = 1'b0;
    bus.axi_wready_i  = 1'b0;
    bus.axi_arready_i = 1'b0;
    bus.axi_bvalid_i  = 1'b0;
    bus.axi_rvalid_i  = 1'b0;
    bus.axi_bresp_i   = 2'b00;
    bus.axi_rresp_i   = 2'b00;
  endtask

  // One request. Slave timing is given as wait counts relative to valid rise:
  // da = cycles before awready/arready, dw = cycles before wready,
  // dr = cycles between the last address/data handshake and bvalid/rvalid.
  // Expected behaviour comes from edge arithmetic: edge 0 samples the request.
  task automatic run_txn(input string name, input bit do_wr, input bit do_rd,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input int da, input int dw,
                         input int dr, input logic [1:0] resp, input logic [31:0] rdat);
    bit   is_wr     = do_wr;
    int   hs        = is_wr ? 1 + ((da > dw) ? da : dw) : 1 + da;
    int   resp_edge = hs + 1 + dr;
    bit   tmo       = (hs >= TMO) || (resp_edge > TMO);
    int   ack_edge  = tmo ? TMO : resp_edge;
    logic exp_err   = tmo ? 1'b1 : resp[1];
    int   aw_end    = is_wr ? ((da + 1 < TMO) ? da + 1 : TMO) : 0;
    int   w_end     = is_wr ? ((dw + 1 < TMO) ? dw + 1 : TMO) : 0;
    int   ar_end    = is_wr ? 0 : ((da + 1 < TMO) ? da + 1 : TMO);
    int   ack_cnt = 0, ack_at = -1;
    logic err_seen = 1'b0;
    bit   bad_aw = 0, bad_w = 0, bad_ar = 0, bad_rsp = 0, bad_pay = 0, bad_err = 0;
    bit   rsp_done = 0;
    bit   exp_rdy;

    bus.sys_addr_i  = addr;
    bus.sys_wdata_i = wdata;
    bus.sys_sel_i   = sel;
    bus.sys_wen_i   = do_wr;
    bus.sys_ren_i   = do_rd;
    @(posedge clk);
    #1;
    bus.sys_wen_i = 1'b0;
    bus.sys_ren_i = 1'b0;

    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      // observe state after edge k
      if (bus.axi_awvalid_o !== (k < aw_end)) bad_aw = 1;
      if (bus.axi_wvalid_o  !== (k < w_end))  bad_w  = 1;
      if (bus.axi_arvalid_o !== (k < ar_end)) bad_ar = 1;
      exp_rdy = (hs < TMO) && (k >= hs) && (k < ack_edge);
      if (bus.axi_bready_o !== (is_wr && exp_rdy))  bad_rsp = 1;
      if (bus.axi_rready_o !== (!is_wr && exp_rdy)) bad_rsp = 1;
      if (bus.axi_awvalid_o === 1'b1 &&
          (bus.axi_awaddr_o !== addr || bus.axi_awlen_o !== 4'd0 ||
           bus.axi_awsize_o !== 3'd2 || bus.axi_awburst_o !== 2'b01 ||
           bus.axi_awid_o !== 8'd0 || bus.axi_awprot_o !== 3'd0)) bad_pay = 1;
      if (bus.axi_wvalid_o === 1'b1 &&
          (bus.axi_wdata_o !== wdata || bus.axi_wstrb_o !== sel ||
           bus.axi_wlast_o !== 1'b1)) bad_pay = 1;
      if (bus.axi_arvalid_o === 1'b1 &&
          (bus.axi_araddr_o !== addr || bus.axi_arlen_o !== 4'd0 ||
           bus.axi_arsize_o !== 3'd2 || bus.axi_arburst_o !== 2'b01)) bad_pay = 1;
      if (bus.sys_ack_o === 1'b1) begin
        ack_cnt++;
        ack_at   = k;
        err_seen = bus.sys_err_o;
      end else if (bus.sys_err_o !== 1'b0) begin
        bad_err = 1;
      end

      // stray requests while busy must be ignored
      bus.sys_wen_i  = (k == 1);
      bus.sys_ren_i  = (k == 1);
      bus.sys_addr_i = (k == 1) ? ~addr : addr;

      // slave drive for edge k+1
      bus.axi_awready_i = is_wr && (k == da);
      bus.axi_wready_i  = is_wr && (k == dw);
      bus.axi_arready_i = !is_wr && (k == da);
      bus.axi_bresp_i   = resp;
      bus.axi_rresp_i   = resp;
      bus.axi_rdata_i   = rdat;
      bus.axi_bvalid_i  = is_wr && (k >= hs + dr) && !rsp_done;
      bus.axi_rvalid_i  = !is_wr && (k >= hs + dr) && !rsp_done;
      if ((bus.axi_bvalid_i && bus.axi_bready_o) || (bus.axi_rvalid_i && bus.axi_rready_o))
        rsp_done = 1;
    end
    idle_inputs();

    if (!is_wr && !tmo) rdata_model = rdat;
    check({name, ".ack_count"}, ack_cnt, 1);
    check({name, ".ack_edge"}, ack_at, ack_edge);
    check({name, ".err"}, err_seen, exp_err);
    check({name, ".aw_w_valid"}, {bad_aw, bad_w}, 2'b00);
    check({name, ".ar_valid"}, bad_ar, 1'b0);
    check({name, ".resp_ready"}, bad_rsp, 1'b0);
    check({name, ".payload"}, bad_pay, 1'b0);
    check({name, ".err_without_ack"}, bad_err, 1'b0);
    check({name, ".rdata"}, bus.sys_rdata_o, rdata_model);
  endtask

  initial begin
    int kind, da, dw, dr;
    logic [1:0] resp;

    rst = 1'b1;
    bus.sys_addr_i  = '0;
    bus.sys_wdata_i = '0;
    bus.sys_sel_i   = '0;
    bus.axi_bid_i   = '0;
    bus.axi_rid_i   = '0;
    bus.axi_rlast_i = 1'b1;
    bus.axi_rdata_i = '0;
    idle_inputs();
    #1;
    check("reset.valids", {bus.axi_awvalid_o, bus.axi_wvalid_o, bus.axi_arvalid_o}, 3'b000);
    check("reset.readys", {bus.axi_bready_o, bus.axi_rready_o}, 2'b00);
    check("reset.ack_err", {bus.sys_ack_o, bus.sys_err_o}, 2'b00);
    check("reset.rdata", bus.sys_rdata_o, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_txn("wr_basic", 1, 0, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0);
    run_txn("rd_wait2", 0, 1, 32'h4000_0020, 32'h0, 4'h0, 2, 0, 0, 2'b00, 32'h1234_5678);
    run_txn("wr_w_first", 1, 0, 32'h4000_0030, 32'hA5A5_0F0F, 4'h3, 4, 0, 0, 2'b10, 32'h0);
    run_txn("wr_and_rd", 1, 1, 32'h4000_0040, 32'h0BAD_F00D, 4'hC, 1, 1, 1, 2'b00, 32'h0);
    run_txn("rd_timeout", 0, 1, 32'h4000_0050, 32'h0, 4'h0, 100, 0, 0, 2'b00, 32'hFFFF_0000);
    run_txn("wr_late_b", 1, 0, 32'h4000_0060, 32'h1111_2222, 4'h1, 0, 0, 35, 2'b00, 32'h0);
    run_txn("rd_edge31", 0, 1, 32'h4000_0070, 32'h0, 4'h0, 0, 0, 30, 2'b01, 32'hCAFE_0001);

    // reset while waiting for the write response
    bus.sys_addr_i  = 32'h4000_0080;
    bus.sys_wdata_i = 32'h5555_AAAA;
    bus.sys_sel_i   = 4'hF;
    bus.sys_wen_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.sys_wen_i     = 1'b0;
    bus.axi_awready_i = 1'b1;
    bus.axi_wready_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.axi_awready_i = 1'b0;
    bus.axi_wready_i  = 1'b0;
    @(negedge clk);
    check("rst_mid.in_wresp", bus.axi_bready_o, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid.outputs",
          {bus.axi_awvalid_o, bus.axi_wvalid_o, bus.axi_bready_o, bus.sys_ack_o, bus.sys_err_o},
          5'b00000);
    check("rst_mid.rdata", bus.sys_rdata_o, 32'h0);
    rdata_model = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn("rd_after_rst", 0, 1, 32'h4000_0090, 32'h0, 4'h0, 1, 0, 1, 2'b00, 32'h8765_4321);

    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      da   = $urandom_range(0, 4);
      dw   = $urandom_range(0, 4);
      dr   = ($urandom_range(0, 7) == 0) ? $urandom_range(24, 34) : $urandom_range(0, 4);
      resp = 2'($urandom_range(0, 3));
      run_txn($sformatf("rand%0d", i), kind != 1, kind != 0, $urandom, $urandom,
              4'($urandom_range(0, 15)), da, dw, dr, resp, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sys_axi_master.md
Name:
sys_axi_master

Overview:
- Converts a single outstanding system-bus request (write or read) into one single-beat AXI3 transaction, and returns the ack, error flag and read data.
- It is the initiator-side counterpart of the PS-facing AXI slave bridge. It lets PL logic (DMA/sequencers) access AXI slaves, including our own register space.

Parameters:
AXI_DW, 32, data width; AXI_SW = AXI_DW>>3 strobe width (derived).
AXI_AW, 32, address width.
AXI_IW, 8, ID width.
AXI_ID, 0, constant ID driven on every channel.
TMO_W, 6, timeout counter width; timeout fires after 2^(TMO_W-1) = 32 cycles.

Ports:
axi_clk_i  in  1  clock, all logic on rising edge.
axi_rst_i  in  1  reset, asynchronous, active-high.
sys_addr_i  in  AXI_AW  request address.
sys_wdata_i  in  AXI_DW  write data.
sys_sel_i  in  AXI_SW  write byte select.
sys_wen_i  in  1  write request pulse.
sys_ren_i  in  1  read request pulse.
sys_rdata_o  out  AXI_DW  read data, registered.
sys_ack_o  out  1  one-cycle completion pulse.
sys_err_o  out  1  error qualifier, valid with sys_ack_o.
axi_awaddr_o  out  AXI_AW  write address.
axi_awvalid_o  out  1  write address valid.
axi_awready_i  in  1  write address ready.
axi_wdata_o  out  AXI_DW  write data.
axi_wstrb_o  out  AXI_SW  write strobes, equal to the latched sys_sel_i.
axi_wvalid_o  out  1  write data valid.
axi_wready_i  in  1  write data ready.
axi_bresp_i  in  2  write response.
axi_bvalid_i  in  1  write response valid.
axi_bready_o  out  1  write response ready.
axi_araddr_o  out  AXI_AW  read address.
axi_arvalid_o  out  1  read address valid.
axi_arready_i  in  1  read address ready.
axi_rdata_i  in  AXI_DW  read data.
axi_rresp_i  in  2  read response.
axi_rvalid_i  in  1  read data valid.
axi_rready_o  out  1  read data ready.
Constant outputs: axi_awid_o, axi_wid_o, axi_arid_o (AXI_IW) = AXI_ID; axi_awlen_o, axi_arlen_o (4) = 0; axi_awsize_o, axi_arsize_o (3) = log2(AXI_SW); axi_awburst_o, axi_arburst_o (2) = 2'b01; axi_wlast_o = 1; axi_awlock_o, axi_arlock_o (2) = 0; axi_awcache_o, axi_arcache_o (4) = 0; axi_awprot_o, axi_arprot_o (3) = 0.
Inputs ignored: axi_bid_i, axi_rid_i (AXI_IW), axi_rlast_i (1).

Behaviour:
- Reset (async): state IDLE; all *valid_o = 0, *ready_o = 0; sys_ack_o = 0, sys_err_o = 0; sys_rdata_o = 0; timeout counter = 0.
- FSM states: IDLE, WREQ, WRESP, RREQ, RRESP.
- IDLE:
  - sys_wen_i: latch addr/wdata/sel, go to WREQ; awvalid_o and wvalid_o rise the next cycle, registered.
  - Otherwise sys_ren_i: latch addr, go to RREQ; arvalid_o rises the next cycle.
  - wen and ren in the same cycle: the write wins and the read is dropped, with no ack for it.
- Requests arriving outside IDLE are ignored. The requester waits for sys_ack_o before issuing the next request.
- WREQ:
  - awvalid_o and wvalid_o each stay high until their own valid&ready handshake, then drop independently; either order or the same cycle is legal.
  - When both handshakes are done, go to WRESP.
- WRESP: bready_o = 1. On bvalid_i: sys_ack_o = 1 next cycle, sys_err_o = bresp_i[1], go to IDLE.
- RREQ: arvalid_o stays high until arready_i, then go to RRESP.
- RRESP: rready_o = 1. On rvalid_i: register rdata_i into sys_rdata_o; sys_ack_o = 1 next cycle, sys_err_o = rresp_i[1]; go to IDLE.
- Minimum latency, request to ack:
  - Write: 3 cycles, with AW/W ready at cycle 1 and bvalid at cycle 2.
  - Read: 3 cycles.
- Address, data and strobe outputs are stable from valid rise until handshake.
- Timeout:
  - The counter is cleared on accept and increments in every non-IDLE state.
  - When counter[TMO_W-1] sets: pulse sys_ack_o with sys_err_o = 1, drop all valid/ready outputs, go to IDLE. sys_rdata_o keeps its old value.
  - A late B or R response after a timeout is not accepted.
- sys_ack_o is high for exactly 1 cycle per accepted request. sys_err_o = 0 whenever sys_ack_o = 0.
- Async reset mid-transaction: outputs return to reset values immediately, with no ack.

Test Plan:
- Write 0x40000010 data 0xDEADBEEF sel 0xF, slave ready immediately, bresp 00 -> awaddr 0x40000010, wstrb 0xF, awlen 0, awsize 2, single aw/w handshake, ack at cycle 3, err = 0.
- Read 0x40000020, arready after 2 waits, rdata 0x12345678, rresp 00 -> arvalid held 3 cycles, sys_rdata_o = 0x12345678 with ack, err = 0.
- Write with W accepted 4 cycles before AW, then bresp 10 -> wvalid drops after its handshake, awvalid holds, ack = 1 with err = 1.
- wen and ren asserted in the same cycle -> only the AW/W channels activate, arvalid stays 0, exactly one ack.
- Slave never answers a read -> ack and err = 1 at cycle 32 after accept, arvalid low afterwards, sys_rdata_o unchanged.
- axi_rst_i pulsed while in WRESP -> awvalid, wvalid, bready and ack are all 0 immediately; the next read completes normally.
